// File: rtl/spi_reg_master_if.sv
// Register-transaction request/response bundle plus the SPI pins
// for the 4 x 8-bit SPI register slave.
interface spi_reg_master_if;
    logic        start;
    logic        rw;
    logic [1:0]  addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        SS;

    modport master (
        input  start, rw, addr, len, wdata, MISO,
        output rdata, busy, done, SCLK, MOSI, SS
    );

    modport slave (
        output start, rw, addr, len, wdata, MISO,
        input  rdata, busy, done, SCLK, MOSI, SS
    );
endinterface

// File: rtl/spi_reg_master.sv
// SPI mode-0 master: one command byte {rw,5'b0,addr} then 1-4 data
// bytes against the 4 x 8-bit register slave; read bytes land in rdata.
module spi_reg_master #(
    parameter int CLK_DIV = 8,
    parameter int GAP_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    spi_reg_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD} state_t;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_M1 = 8'(GAP_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [2:0]  byte_q, byte_d;
    logic        rw_q, rw_d;
    logic [1:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_q, rx_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        ss_q, ss_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        last_byte;
    logic [4:0]  rd_base;
    logic [4:0]  wd_base;
    logic [7:0]  nxt_byte;

    assign last_byte = (byte_q == ({1'b0, len_q} + 3'd1));
    assign rd_base   = {byte_q[1:0] - 2'd1, 3'b000};
    assign wd_base   = {byte_q[1:0], 3'b000};
    assign nxt_byte  = rw_q ? wdata_q[wd_base +: 8] : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            rw_q    <= 1'b0;
            len_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            shift_q <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ss_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            rw_q    <= rw_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ss_q    <= ss_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        rw_d    = rw_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        ss_d    = ss_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rw_d    = bus.rw;
                    len_d   = bus.len;
                    wdata_d = bus.wdata;
                    rdata_d = '0;
                    shift_d = {bus.rw, 5'b0, bus.addr};
                    mosi_d  = bus.rw;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SHIFT: begin
                if (cnt_q != DIV_M1) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], bus.MISO};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q != 3'd7) begin
                            bit_d   = bit_q + 3'd1;
                            shift_d = {shift_q[6:0], 1'b0};
                            mosi_d  = shift_q[6];
                        end else begin
                            bit_d  = '0;
                            byte_d = byte_q + 3'd1;
                            if (!rw_q && byte_q != 3'd0) begin
                                rdata_d[rd_base +: 8] = rx_q;
                            end
                            if (last_byte) begin
                                state_d = HOLD;
                            end else begin
                                // next byte is loaded while SCLK sits low
                                shift_d = nxt_byte;
                                mosi_d  = nxt_byte[7];
                                state_d = (GAP_CYC == 0) ? SHIFT : GAP;
                            end
                        end
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_M1) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d   = '0;
                    ss_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.SCLK  = sclk_q;
    assign bus.MOSI  = mosi_q;
    assign bus.SS    = ss_q;
endmodule

// File: tb/tb_spi_reg_master.sv
// Scoreboard bench: two masters (GAP_CYC=16 and 0) each talking to a
// behavioural 4 x 8-bit register slave.
module tb_spi_reg_master;
    localparam int DIV = 4;

    typedef struct {
        int          nb;
        logic [39:0] mosi;
        logic [31:0] rdata;
        int          t0;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t        q[2][$];
    logic [7:0]  regs[2][4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_reg_master_if ifa ();
    spi_reg_master_if ifb ();

    spi_reg_master #(.CLK_DIV(DIV), .GAP_CYC(16)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.master)
    );
    spi_reg_master #(.CLK_DIV(DIV), .GAP_CYC(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.master)
    );

    wire [1:0]  sclk_w = {ifb.SCLK, ifa.SCLK};
    wire [1:0]  mosi_w = {ifb.MOSI, ifa.MOSI};
    wire [1:0]  ss_w   = {ifb.SS, ifa.SS};
    wire [1:0]  done_w = {ifb.done, ifa.done};
    wire [1:0]  busy_w = {ifb.busy, ifa.busy};
    wire [31:0] rd_w[2];
    logic       miso_w[2];
    assign rd_w[0]  = ifa.rdata;
    assign rd_w[1]  = ifb.rdata;
    assign ifa.MISO = miso_w[0];
    assign ifb.MISO = miso_w[1];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    function automatic int lat_f(input int len, input int g);
        int n;
        int gg;
        n  = len + 2;
        gg = (g == 0) ? 16 : 0;
        return 1 + DIV + n*16*DIV - DIV*(n-1) + (n-1)*(gg+DIV) + DIV;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int GV = (g == 0) ? 16 : 0;
        int          rises, lowc, badlow, sbit, sbyte;
        logic [39:0] acc;
        logic [7:0]  sh, outb;
        logic        srw;
        logic [1:0]  ptr;
        exp_t        e;

        initial begin
            rises = 0; lowc = 0; badlow = 0; sbit = 0; sbyte = 0;
            acc = '0; sh = '0; outb = '0; srw = 1'b1; ptr = '0;
            for (int i = 0; i < 4; i++) regs[g][i] = 8'h00;
        end

        always @(negedge ss_w[g]) begin
            rises = 0; lowc = 0; badlow = 0; acc = '0;
            sbit = 0; sbyte = 0;
        end

        // slave shifts on the rise and presents the next MISO bit after it
        always @(posedge sclk_w[g]) begin
            if (!ss_w[g]) begin
                int el;
                el = (rises == 0) ? 2*DIV :
                     ((rises % 8 == 0) ? GV + DIV : DIV);
                if (lowc != el) badlow++;
                lowc = 0;
                rises++;
                acc = {acc[38:0], mosi_w[g]};
                sh = {sh[6:0], mosi_w[g]};
                sbit++;
                if (sbit == 8) begin
                    sbit = 0;
                    if (sbyte == 0) begin
                        srw  = sh[7];
                        ptr  = sh[1:0];
                        outb = regs[g][ptr];
                    end else if (srw) begin
                        regs[g][ptr] = sh;
                        ptr++;
                    end else begin
                        ptr++;
                        outb = regs[g][ptr];
                    end
                    sbyte++;
                end
            end
        end

        assign miso_w[g] = (!ss_w[g] && sbyte > 0 && !srw) ?
                           outb[3'(7 - sbit)] : 1'b0;

        always @(negedge clk) begin
            if (!ss_w[g] && !sclk_w[g]) lowc++;
            if (done_w[g]) begin
                if (q[g].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done dut%0d: got 1 want 0", g);
                end else begin
                    e = q[g].pop_front();
                    chk("rises", 64'(rises), 64'(8*e.nb));
                    chk("mosi", 64'(acc), 64'(e.mosi));
                    chk("rdata", 64'(rd_w[g]), 64'(e.rdata));
                    chk("latency", 64'(cyc - e.t0), 64'(e.lat));
                    chk("busy_at_done", 64'(busy_w[g]), 64'd0);
                    chk("sclk_low_len", 64'(badlow), 64'd0);
                end
            end
        end
    end

    task automatic go(input int g, input bit push, input logic rw,
                      input logic [1:0] a, input logic [1:0] l,
                      input logic [31:0] wd, input logic [39:0] mo,
                      input logic [31:0] rd);
        exp_t e;
        if (g == 0) begin
            ifa.rw = rw; ifa.addr = a; ifa.len = l;
            ifa.wdata = wd; ifa.start = 1'b1;
        end else begin
            ifb.rw = rw; ifb.addr = a; ifb.len = l;
            ifb.wdata = wd; ifb.start = 1'b1;
        end
        if (push) begin
            e.nb = int'(l) + 2;
            e.mosi = mo;
            e.rdata = rd;
            e.t0 = cyc;
            e.lat = lat_f(int'(l), g);
            q[g].push_back(e);
        end
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
    endtask

    task automatic drain(input int g);
        for (int i = 0; i < 4000 && q[g].size() != 0; i++) @(negedge clk);
        chk("drain_timeout", 64'(q[g].size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int r;
        ifa.start = 0; ifa.rw = 0; ifa.addr = 0; ifa.len = 0; ifa.wdata = 0;
        ifb.start = 0; ifb.rw = 0; ifb.addr = 0; ifb.len = 0; ifb.wdata = 0;
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ss", 64'(ifa.SS), 64'd1);
        chk("rst_sclk", 64'(ifa.SCLK), 64'd0);
        chk("rst_mosi", 64'(ifa.MOSI), 64'd0);
        chk("rst_busy", 64'(ifa.busy), 64'd0);
        chk("rst_done", 64'(ifa.done), 64'd0);
        chk("rst_rdata", 64'(ifa.rdata), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        go(0, 1, 1'b1, 2'd2, 2'd0, 32'h0000_00A5, 40'h82A5, 32'h0);
        drain(0);

        go(0, 1, 1'b1, 2'd3, 2'd3, 32'h4433_2211, 40'h83_1122_3344, 32'h0);
        drain(0);
        chk("reg3", 64'(regs[0][3]), 64'h11);
        chk("reg0", 64'(regs[0][0]), 64'h22);
        chk("reg1", 64'(regs[0][1]), 64'h33);
        chk("reg2", 64'(regs[0][2]), 64'h44);

        regs[0][1] = 8'h3C;
        regs[0][2] = 8'hC3;
        go(0, 1, 1'b0, 2'd1, 2'd1, 32'h0, 40'h01_0000, 32'h0000_C33C);
        drain(0);

        go(0, 1, 1'b1, 2'd0, 2'd1, 32'h0000_BEEF, 40'h80_EFBE, 32'h0);
        repeat (48) @(negedge clk);
        go(0, 0, 1'b0, 2'd3, 2'd3, 32'h1234_5678, 40'h0, 32'h0);
        drain(0);

        go(0, 1, 1'b1, 2'd1, 2'd0, 32'h0000_005A, 40'h815A, 32'h0);
        for (int i = 0; i < 2000 && !ifa.done; i++) @(negedge clk);
        chk("b2b_done_seen", 64'(ifa.done), 64'd1);
        chk("b2b_ss_high", 64'(ifa.SS), 64'd1);
        go(0, 1, 1'b0, 2'd2, 2'd0, 32'h0, 40'h0200, 32'h0000_00C3);
        chk("b2b_ss_low_next", 64'(ifa.SS), 64'd0);
        drain(0);

        go(1, 1, 1'b1, 2'd0, 2'd2, 32'h00CC_BBAA, 40'h80AA_BBCC, 32'h0);
        drain(1);
        chk("b_reg0", 64'(regs[1][0]), 64'hAA);
        chk("b_reg2", 64'(regs[1][2]), 64'hCC);

        go(0, 0, 1'b0, 2'd1, 2'd1, 32'h0, 40'h0, 32'h0);
        repeat (169) @(negedge clk);
        chk("mid_rdata", 64'(ifa.rdata), 64'h5A);
        chk("mid_busy", 64'(ifa.busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ss", 64'(ifa.SS), 64'd1);
        chk("mid_rst_sclk", 64'(ifa.SCLK), 64'd0);
        chk("mid_rst_mosi", 64'(ifa.MOSI), 64'd0);
        chk("mid_rst_busy", 64'(ifa.busy), 64'd0);
        chk("mid_rst_done", 64'(ifa.done), 64'd0);
        chk("mid_rst_rdata", 64'(ifa.rdata), 64'd0);
        r = mon[0].rises;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("post_rst_rises", 64'(mon[0].rises), 64'(r));
        chk("post_rst_ss", 64'(ifa.SS), 64'd1);
        chk("q_a_empty", 64'(q[0].size()), 64'd0);
        chk("q_b_empty", 64'(q[1].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
